// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// This is the instruction fetch stage that feeds decode. It issues one
// doubleword read per cycle to unified memory read port 0 while it holds
// enough credit. One cycle later it takes the addressed 32-bit big-endian word
// from the returned doubleword. That word is queued together with its PC. The
// head of the queue is offered to decode through a valid/ready handshake. A
// redirect flushes the queue and drops any in-flight response. Fetch then
// restarts at the new PC.
//
// Parameters:
//   RESET_PC      fetch PC loaded on reset (bits [1:0] must be 0)
//   DEPTH         instruction queue entries (power of two, >= 2)
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         synchronous, active-high reset (overrides redirect)
//   memReadEn     read enable to memory read port 0
//   memReadAddr   doubleword address (pc[63:3]), meaningful when memReadEn=1
//   memReadData   read data, valid the cycle after memReadEn=1
//   redirectValid flush everything and restart fetch at redirectPc
//   redirectPc    new fetch PC, bits [1:0] treated as 0
//   instValid     queue head holds a valid instruction
//   instPc        PC of the queue head
//   inst          instruction word at the queue head
//   instReady     decode accepts the head this cycle
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        memReadEn,
   output logic [63:3] memReadAddr,
   input  logic [63:0] memReadData,
   input  logic        redirectValid,
   input  logic [63:0] redirectPc,
   output logic        instValid,
   output logic [63:0] instPc,
   output logic [31:0] inst,
   input  logic        instReady
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   // One bit wider than count so that count + inFlight can never wrap.
   localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

   // Fetch and in-flight tracking.
   logic [63:0]       pc;
   logic              inFlight;
   logic [63:0]       inFlightPc;

   // Instruction queue.
   logic [63:0]       queuePc   [DEPTH];
   logic [31:0]       queueInst [DEPTH];
   logic [PTR_W-1:0]  headPtr;
   logic [PTR_W-1:0]  tailPtr;
   logic [CNT_W-1:0]  count;

   // Per-cycle decisions.
   logic [CNT_W:0]    occupancy;
   logic              issue;
   logic              push;
   logic              pop;
   logic [31:0]       respWord;

   // The low PC bits of a redirect target are forced to zero and never read.
   logic [1:0]        unusedRedirectBits;
   assign unusedRedirectBits = redirectPc[1:0];

   // NOTE: every signal written here is assigned on every path, so no latch is inferred.
   always_comb begin
      // Credit: queued entries plus the outstanding response must fit the queue.
      occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inFlight};
      issue     = !reset && !redirectValid && (occupancy < DEPTH_OCC);
      // Memory data is only meaningful the cycle after an enabled read.
      push      = !reset && !redirectValid && inFlight;
      pop       = instValid && instReady;
      // Big-endian: the lower address word sits in the upper half.
      respWord  = inFlightPc[2] ? memReadData[31:0] : memReadData[63:32];
   end

   assign memReadEn   = issue;
   assign memReadAddr = pc[63:3];
   assign instValid   = (count != '0);
   assign instPc      = queuePc[headPtr];
   assign inst        = queueInst[headPtr];

   // NOTE: state registers use non-blocking assignments so every process sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= RESET_PC;
         inFlight   <= 1'b0;
         inFlightPc <= RESET_PC;
         headPtr    <= '0;
         tailPtr    <= '0;
         count      <= '0;
      end else if (redirectValid) begin
         // A head popped this cycle is still a completed handoff. Everything
         // else is dropped, including the response that returns next cycle.
         pc       <= {redirectPc[63:2], 2'b00};
         inFlight <= 1'b0;
         headPtr  <= '0;
         tailPtr  <= '0;
         count    <= '0;
      end else begin
         inFlight <= issue;
         if (issue) begin
            inFlightPc <= pc;
            pc         <= pc + 64'd4;
         end
         if (push) tailPtr <= tailPtr + PTR_W'(1);
         if (pop)  headPtr <= headPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: queue storage has no reset; count gates every read through instValid.
   always_ff @(posedge clk) begin
      if (push) begin
         queuePc[tailPtr]   <= inFlightPc;
         queueInst[tailPtr] <= respWord;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed testbench for fetch_unit. A behavioural memory returns one
// doubleword the cycle after each enabled read. When the read is not enabled
// the memory holds its stale data.
// Doubleword 0 is 11111111_22222222 and doubleword 1 is 33333333_44444444.
// Every other doubleword a is {A0,a[23:0],B0,a[23:0]}.
// Inputs change 1 ns after a rising edge. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        memReadEn;
   logic [63:3] memReadAddr;
   logic [63:0] memReadData;
   logic        redirectValid;
   logic [63:0] redirectPc;
   logic        instValid;
   logic [63:0] instPc;
   logic [31:0] inst;
   logic        instReady;

   int checkCount = 0;
   int failCount  = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .memReadEn     (memReadEn),
      .memReadAddr   (memReadAddr),
      .memReadData   (memReadData),
      .redirectValid (redirectValid),
      .redirectPc    (redirectPc),
      .instValid     (instValid),
      .instPc        (instPc),
      .inst          (inst),
      .instReady     (instReady)
   );

   function automatic logic [63:0] memWord(input logic [60:0] a);
      if (a == 61'd0) return 64'h11111111_22222222;
      if (a == 61'd1) return 64'h33333333_44444444;
      return {8'hA0, a[23:0], 8'hB0, a[23:0]};
   endfunction

   always @(posedge clk) begin
      if (memReadEn === 1'b1) memReadData <= memWord(memReadAddr);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // A response may only be pushed while the queue has room for it.
   always @(negedge clk) begin
      if (reset === 1'b0 && redirectValid === 1'b0 && dut.inFlight === 1'b1)
         check("push_not_full", 64'(dut.count < DEPTH), 64'd1);
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic expectHead(input string tag, input logic [63:0] p, input logic [31:0] w);
      check({tag, "_valid"}, 64'(instValid), 64'd1);
      check({tag, "_pc"}, instPc, p);
      check({tag, "_inst"}, 64'(inst), 64'(w));
   endtask

   // Returns 1 ns into cycle 0 with reset just released.
   task automatic applyReset();
      reset         = 1'b1;
      redirectValid = 1'b0;
      redirectPc    = '0;
      instReady     = 1'b0;
      repeat (2) nextCycle();
      sample();
      check("rst_en", 64'(memReadEn), 64'd0);
      check("rst_valid", 64'(instValid), 64'd0);
      nextCycle();
      reset = 1'b0;
   endtask

   logic [63:0] coldAddr  [4] = '{64'h0, 64'h0, 64'h1, 64'h1};
   logic [63:0] seqPc     [5] = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10};
   logic [31:0] seqInst   [5] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                  32'h44444444, 32'hA0000002};

   initial begin
      reset         = 1'b1;
      redirectValid = 1'b0;
      redirectPc    = '0;
      instReady     = 1'b0;

      // Cold start with decode always ready.
      applyReset();
      instReady = 1'b1;
      for (int c = 0; c < 6; c++) begin
         sample();
         if (c < 4) begin
            check("cold_en", 64'(memReadEn), 64'd1);
            check("cold_addr", 64'(memReadAddr), coldAddr[c]);
         end
         if (c < 2) check("cold_empty", 64'(instValid), 64'd0);
         else       expectHead("cold", seqPc[c-2], seqInst[c-2]);
         nextCycle();
      end

      // Backpressure until the queue is full, then release and drain.
      applyReset();
      for (int c = 0; c < 13; c++) begin
         if (c == 8) instReady = 1'b1;
         sample();
         check("bp_en", 64'(memReadEn), (c < 4 || c > 8) ? 64'd1 : 64'd0);
         if (c < 2)      check("bp_empty", 64'(instValid), 64'd0);
         else if (c < 8) expectHead("bp_hold", 64'h0, 32'h11111111);
         else            expectHead("bp_drain", seqPc[c-8], seqInst[c-8]);
         nextCycle();
      end

      // Redirect to 0x104 at cycle 3 while the fetch of 0x8 is in flight.
      applyReset();
      instReady = 1'b1;
      for (int c = 0; c < 8; c++) begin
         redirectValid = (c == 3);
         redirectPc    = 64'h104;
         sample();
         case (c)
            3: begin
               check("rd_t_en", 64'(memReadEn), 64'd0);
               expectHead("rd_t_head", 64'h4, 32'h22222222);
            end
            4: begin
               check("rd_t1_valid", 64'(instValid), 64'd0);
               check("rd_t1_en", 64'(memReadEn), 64'd1);
               check("rd_t1_addr", 64'(memReadAddr), 64'h20);
            end
            5: check("rd_t2_valid", 64'(instValid), 64'd0);
            6: expectHead("rd_t3", 64'h104, 32'hB0000020);
            7: expectHead("rd_t4", 64'h108, 32'hA0000021);
            default: ;
         endcase
         nextCycle();
      end

      // Redirect with an unaligned target: 0x10B behaves as 0x108.
      for (int c = 0; c < 5; c++) begin
         redirectValid = (c == 0);
         redirectPc    = 64'h10B;
         sample();
         case (c)
            0: check("ua_t_en", 64'(memReadEn), 64'd0);
            1: begin
               check("ua_t1_addr", 64'(memReadAddr), 64'h21);
               check("ua_t1_en", 64'(memReadEn), 64'd1);
               check("ua_t1_valid", 64'(instValid), 64'd0);
            end
            3: expectHead("ua_t3", 64'h108, 32'hA0000021);
            4: expectHead("ua_t4", 64'h10C, 32'hB0000021);
            default: ;
         endcase
         nextCycle();
      end

      // Reset with three entries queued and the fourth request in flight.
      applyReset();
      repeat (4) nextCycle();
      reset = 1'b1;
      sample();
      check("mr_en_in_reset", 64'(memReadEn), 64'd0);
      nextCycle();
      sample();
      check("mr_valid", 64'(instValid), 64'd0);
      check("mr_en", 64'(memReadEn), 64'd0);
      nextCycle();
      reset     = 1'b0;
      instReady = 1'b1;
      for (int c = 0; c < 4; c++) begin
         sample();
         if (c == 0) begin
            check("mr_c0_en", 64'(memReadEn), 64'd1);
            check("mr_c0_addr", 64'(memReadAddr), 64'h0);
         end
         if (c < 2) check("mr_empty", 64'(instValid), 64'd0);
         else       expectHead("mr_head", seqPc[c-2], seqInst[c-2]);
         nextCycle();
      end

      // Redirect in the same cycle as a head handshake on a full queue.
      applyReset();
      repeat (6) nextCycle();
      for (int c = 6; c < 12; c++) begin
         instReady     = 1'b1;
         redirectValid = (c == 6);
         redirectPc    = 64'h200;
         sample();
         case (c)
            6: expectHead("hs_t", 64'h0, 32'h11111111);
            7: begin
               check("hs_t1_valid", 64'(instValid), 64'd0);
               check("hs_t1_addr", 64'(memReadAddr), 64'h40);
            end
            8: check("hs_t2_valid", 64'(instValid), 64'd0);
            9: expectHead("hs_t3", 64'h200, 32'hA0000040);
            10: expectHead("hs_t4", 64'h204, 32'hB0000040);
            11: expectHead("hs_t5", 64'h208, 32'hA0000041);
            default: ;
         endcase
         nextCycle();
      end

      // The fetch PC wraps from the top of the address space to zero.
      for (int c = 0; c < 5; c++) begin
         redirectValid = (c == 0);
         redirectPc    = 64'hFFFF_FFFF_FFFF_FFFC;
         sample();
         case (c)
            1: check("wr_t1_addr", 64'(memReadAddr), 64'h1FFF_FFFF_FFFF_FFFF);
            2: begin
               check("wr_t2_addr", 64'(memReadAddr), 64'h0);
               check("wr_t2_en", 64'(memReadEn), 64'd1);
            end
            3: expectHead("wr_t3", 64'hFFFF_FFFF_FFFF_FFFC, 32'hB0FFFFFF);
            4: expectHead("wr_t4", 64'h0, 32'h11111111);
            default: ;
         endcase
         nextCycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
